// File: rtl/idu_inst_enc_ysyx_23060136_pkg.sv
// Shared constants for the RV32 instruction encoder: format indices, opcodes,
// immediate bounds and the immediate range helper used by IDU_INST_ENC_RANGE_CHECK_EN.
package idu_inst_enc_ysyx_23060136_pkg;

  localparam int FMT_R = 0;
  localparam int FMT_I = 1;
  localparam int FMT_S = 2;
  localparam int FMT_B = 3;
  localparam int FMT_U = 4;
  localparam int FMT_J = 5;
  localparam int FMT_W = 6;

  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;

  localparam logic signed [31:0] IMM12_MIN = -32'sd2048;
  localparam logic signed [31:0] IMM12_MAX = 32'sd2047;
  localparam logic signed [31:0] IMM13_MIN = -32'sd4096;
  localparam logic signed [31:0] IMM13_MAX = 32'sd4094;
  localparam logic signed [31:0] IMM21_MIN = -32'sd1048576;
  localparam logic signed [31:0] IMM21_MAX = 32'sd1048574;

  localparam int FIFO_DEPTH = 2;

  // Only meaningful for a one-hot fmt; R-type never carries an immediate.
  function automatic logic imm_out_of_range(input logic [FMT_W-1:0] fmt,
                                            input logic [31:0] imm);
    logic signed [31:0] simm;
    logic bad;
    simm = $signed(imm);
    bad  = 1'b0;
    if (fmt[FMT_I] || fmt[FMT_S])
      bad = (simm < IMM12_MIN) || (simm > IMM12_MAX);
    else if (fmt[FMT_B])
      bad = (simm < IMM13_MIN) || (simm > IMM13_MAX) || imm[0];
    else if (fmt[FMT_J])
      bad = (simm < IMM21_MIN) || (simm > IMM21_MAX) || imm[0];
    else if (fmt[FMT_U])
      bad = (imm[11:0] != 12'h000);
    return bad;
  endfunction

endpackage

// File: rtl/idu_enc_fifo_ysyx_23060136.sv
// Two-entry in-order buffer holding {err, inst}; ready depends on registered occupancy only.
module idu_enc_fifo_ysyx_23060136
  import idu_inst_enc_ysyx_23060136_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        push_valid,
  output logic        push_ready,
  input  logic [32:0] push_data,
  output logic        pop_valid,
  input  logic        pop_ready,
  output logic [32:0] pop_data
);

  logic [32:0] mem [FIFO_DEPTH];
  logic        wr_ptr;
  logic        rd_ptr;
  logic [1:0]  count;
  logic        push;
  logic        pop;

  assign push_ready = (count < 2'(FIFO_DEPTH));
  assign pop_valid  = (count != 2'd0);
  assign pop_data   = pop_valid ? mem[rd_ptr] : 33'h0;
  assign push       = push_valid && push_ready;
  assign pop        = pop_valid && pop_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mem[0] <= 33'h0;
      mem[1] <= 33'h0;
      wr_ptr <= 1'b0;
      rd_ptr <= 1'b0;
      count  <= 2'd0;
    end else begin
      if (push) begin
        mem[wr_ptr] <= push_data;
        wr_ptr      <= ~wr_ptr;
      end
      if (pop)
        rd_ptr <= ~rd_ptr;
      // Simultaneous push and pop leaves occupancy unchanged.
      case ({push, pop})
        2'b10:   count <= count + 2'd1;
        2'b01:   count <= count - 2'd1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/idu_inst_enc_ysyx_23060136.sv
// RV32 instruction encoder with a 2-entry response buffer and saturating error counter.
// Define IDU_INST_ENC_RANGE_CHECK_EN to also flag immediates not representable in the format.
module idu_inst_enc_ysyx_23060136
  import idu_inst_enc_ysyx_23060136_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic        op_R_type,
  input  logic        op_I_type,
  input  logic        op_S_type,
  input  logic        op_B_type,
  input  logic        op_U_type,
  input  logic        op_J_type,
  input  logic [6:0]  in_opcode,
  input  logic [4:0]  in_rd,
  input  logic [4:0]  in_rs1,
  input  logic [4:0]  in_rs2,
  input  logic [2:0]  in_funct3,
  input  logic [6:0]  in_funct7,
  input  logic [31:0] in_imm,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_inst,
  output logic        out_err,
  output logic [7:0]  err_cnt,
  input  logic        err_clr
);

  logic [FMT_W-1:0] fmt;
  logic             fmt_onehot;
  logic             range_err;
  logic [31:0]      enc_inst;
  logic             enc_err;
  logic [32:0]      pop_data;

  assign fmt        = {op_J_type, op_U_type, op_B_type, op_S_type, op_I_type, op_R_type};
  assign fmt_onehot = (fmt != '0) && ((fmt & (fmt - 6'd1)) == '0);

`ifdef IDU_INST_ENC_RANGE_CHECK_EN
  assign range_err = fmt_onehot && imm_out_of_range(fmt, in_imm);
`else
  assign range_err = 1'b0;
`endif

  assign enc_err = !fmt_onehot || range_err;

  always_comb begin
    enc_inst = 32'h0;
    if (fmt_onehot) begin
      enc_inst[6:0] = in_opcode;
      if (fmt[FMT_R] || fmt[FMT_I] || fmt[FMT_U] || fmt[FMT_J])
        enc_inst[11:7] = in_rd;
      if (fmt[FMT_R] || fmt[FMT_I] || fmt[FMT_S] || fmt[FMT_B]) begin
        enc_inst[14:12] = in_funct3;
        enc_inst[19:15] = in_rs1;
      end
      if (fmt[FMT_R] || fmt[FMT_S] || fmt[FMT_B])
        enc_inst[24:20] = in_rs2;
      if (fmt[FMT_R])
        enc_inst[31:25] = in_funct7;
      if (fmt[FMT_I])
        enc_inst[31:20] = in_imm[11:0];
      if (fmt[FMT_S]) begin
        enc_inst[31:25] = in_imm[11:5];
        enc_inst[11:7]  = in_imm[4:0];
      end
      if (fmt[FMT_B]) begin
        enc_inst[31]    = in_imm[12];
        enc_inst[30:25] = in_imm[10:5];
        enc_inst[11:8]  = in_imm[4:1];
        enc_inst[7]     = in_imm[11];
      end
      if (fmt[FMT_U])
        enc_inst[31:12] = in_imm[31:12];
      if (fmt[FMT_J]) begin
        enc_inst[31]    = in_imm[20];
        enc_inst[30:21] = in_imm[10:1];
        enc_inst[20]    = in_imm[11];
        enc_inst[19:12] = in_imm[19:12];
      end
    end
  end

  idu_enc_fifo_ysyx_23060136 u_fifo (
    .clk        (clk),
    .rst_n      (rst_n),
    .push_valid (in_valid),
    .push_ready (in_ready),
    .push_data  ({enc_err, enc_inst}),
    .pop_valid  (out_valid),
    .pop_ready  (out_ready),
    .pop_data   (pop_data)
  );

  assign out_err  = pop_data[32];
  assign out_inst = pop_data[31:0];

  // Clear wins over a same-cycle erroneous pop.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      err_cnt <= 8'h0;
    else if (err_clr)
      err_cnt <= 8'h0;
    else if (out_valid && out_ready && out_err && (err_cnt != 8'hFF))
      err_cnt <= err_cnt + 8'd1;
  end

endmodule

// File: tb/tb_idu_inst_enc_ysyx_23060136.sv
// Directed self-checking bench for idu_inst_enc_ysyx_23060136 (encoding, errors, buffering, reset).
module tb_idu_inst_enc_ysyx_23060136;
  import idu_inst_enc_ysyx_23060136_pkg::*;

  logic        clk;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic        op_R_type, op_I_type, op_S_type, op_B_type, op_U_type, op_J_type;
  logic [6:0]  in_opcode;
  logic [4:0]  in_rd, in_rs1, in_rs2;
  logic [2:0]  in_funct3;
  logic [6:0]  in_funct7;
  logic [31:0] in_imm;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_inst;
  logic        out_err;
  logic [7:0]  err_cnt;
  logic        err_clr;

  int checks;
  int errors;
  int exp_err_cnt;

  localparam logic [5:0] T_R = 6'b000001;
  localparam logic [5:0] T_I = 6'b000010;
  localparam logic [5:0] T_S = 6'b000100;
  localparam logic [5:0] T_B = 6'b001000;
  localparam logic [5:0] T_U = 6'b010000;
  localparam logic [5:0] T_J = 6'b100000;

  idu_inst_enc_ysyx_23060136 dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .op_R_type (op_R_type),
    .op_I_type (op_I_type),
    .op_S_type (op_S_type),
    .op_B_type (op_B_type),
    .op_U_type (op_U_type),
    .op_J_type (op_J_type),
    .in_opcode (in_opcode),
    .in_rd     (in_rd),
    .in_rs1    (in_rs1),
    .in_rs2    (in_rs2),
    .in_funct3 (in_funct3),
    .in_funct7 (in_funct7),
    .in_imm    (in_imm),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_inst  (out_inst),
    .out_err   (out_err),
    .err_cnt   (err_cnt),
    .err_clr   (err_clr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("[TB] FAIL watchdog actual=timeout required=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string tag, input logic [31:0] actual,
                             input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s actual=%h required=%h", tag, actual, expected);
    end
  endtask

  task automatic driveFields(input logic [5:0] fmt, input logic [6:0] opc,
                             input logic [4:0] rd, input logic [4:0] rs1,
                             input logic [4:0] rs2, input logic [2:0] f3,
                             input logic [6:0] f7, input logic [31:0] imm);
    {op_J_type, op_U_type, op_B_type, op_S_type, op_I_type, op_R_type} = fmt;
    in_opcode = opc;
    in_rd     = rd;
    in_rs1    = rs1;
    in_rs2    = rs2;
    in_funct3 = f3;
    in_funct7 = f7;
    in_imm    = imm;
  endtask

  // Called at a falling edge; returns just after the accepting rising edge.
  task automatic applyStimulus(input logic [5:0] fmt, input logic [6:0] opc,
                               input logic [4:0] rd, input logic [4:0] rs1,
                               input logic [4:0] rs2, input logic [2:0] f3,
                               input logic [6:0] f7, input logic [31:0] imm);
    int n;
    driveFields(fmt, opc, rd, rs1, rs2, f3, f7, imm);
    in_valid = 1'b1;
    n = 0;
    while (!in_ready && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (n >= 20) checkOutput("accept_timeout", 32'(in_ready), 32'd1);
    @(posedge clk);
    #1 in_valid = 1'b0;
  endtask

  task automatic sendAndCheck(input string tag, input logic [5:0] fmt,
                              input logic [6:0] opc, input logic [4:0] rd,
                              input logic [4:0] rs1, input logic [4:0] rs2,
                              input logic [2:0] f3, input logic [6:0] f7,
                              input logic [31:0] imm, input logic [31:0] exp_inst,
                              input logic exp_err);
    applyStimulus(fmt, opc, rd, rs1, rs2, f3, f7, imm);
    @(negedge clk);
    checkOutput({tag, "_valid"}, 32'(out_valid), 32'd1);
    checkOutput({tag, "_inst"}, out_inst, exp_inst);
    checkOutput({tag, "_err"}, 32'(out_err), 32'(exp_err));
    if (exp_err && exp_err_cnt < 255) exp_err_cnt++;
    @(negedge clk);
    checkOutput({tag, "_cnt"}, 32'(err_cnt), 32'(exp_err_cnt));
  endtask

  initial begin
    checks      = 0;
    errors      = 0;
    exp_err_cnt = 0;
    rst_n       = 1'b0;
    in_valid    = 1'b0;
    out_ready   = 1'b1;
    err_clr     = 1'b0;
    driveFields(6'b0, 7'h0, 5'h0, 5'h0, 5'h0, 3'h0, 7'h0, 32'h0);

    #12;
    checkOutput("rst_out_valid", 32'(out_valid), 32'd0);
    checkOutput("rst_in_ready", 32'(in_ready), 32'd1);
    checkOutput("rst_out_inst", out_inst, 32'h0);
    checkOutput("rst_out_err", 32'(out_err), 32'd0);
    checkOutput("rst_err_cnt", 32'(err_cnt), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    // Latency: nothing visible before the accepting edge.
    driveFields(T_I, OPC_OP_IMM, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'd5);
    in_valid = 1'b1;
    #1 checkOutput("lat_pre_valid", 32'(out_valid), 32'd0);
    @(negedge clk);
    sendAndCheck("addi", T_I, OPC_OP_IMM, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'd5,
                 32'h00500093, 1'b0);
    sendAndCheck("beq_neg", T_B, OPC_BRANCH, 5'd0, 5'd0, 5'd0, 3'd0, 7'd0,
                 32'hFFFFFFFC, 32'hFE000EE3, 1'b0);
    sendAndCheck("jal", T_J, OPC_JAL, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'h800,
                 32'h001000EF, 1'b0);
    sendAndCheck("sub", T_R, OPC_OP, 5'd3, 5'd4, 5'd5, 3'd0, 7'b0100000,
                 32'hDEADBEEF, 32'h405201B3, 1'b0);
    sendAndCheck("sw", T_S, OPC_STORE, 5'd31, 5'd1, 5'd2, 3'd2, 7'h7F,
                 32'hFFFFFFFC, 32'hFE20AE23, 1'b0);
    sendAndCheck("lui", T_U, OPC_LUI, 5'd5, 5'd31, 5'd31, 3'd7, 7'h7F,
                 32'h12345000, 32'h123452B7, 1'b0);

    // Two format bits set, then zero bits set with a clear landing on the pop.
    sendAndCheck("two_hot", T_I | T_S, OPC_OP_IMM, 5'd1, 5'd2, 5'd3, 3'd1, 7'd1,
                 32'd5, 32'h0, 1'b1);
    applyStimulus(6'b0, OPC_OP_IMM, 5'd1, 5'd2, 5'd3, 3'd1, 7'd1, 32'd5);
    @(negedge clk);
    checkOutput("zero_hot_inst", out_inst, 32'h0);
    checkOutput("zero_hot_err", 32'(out_err), 32'd1);
    err_clr = 1'b1;
    @(negedge clk);
    err_clr = 1'b0;
    exp_err_cnt = 0;
    checkOutput("clr_priority_cnt", 32'(err_cnt), 32'd0);

`ifdef IDU_INST_ENC_RANGE_CHECK_EN
    sendAndCheck("addi_2048", T_I, OPC_OP_IMM, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0,
                 32'd2048, 32'h80000093, 1'b1);
`else
    sendAndCheck("addi_2048", T_I, OPC_OP_IMM, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0,
                 32'd2048, 32'h80000093, 1'b0);
`endif

    // Stream erroneous requests back to back to drive the counter into saturation.
    driveFields(6'b0, OPC_OP, 5'd0, 5'd0, 5'd0, 3'd0, 7'd0, 32'h0);
    in_valid = 1'b1;
    for (int i = 0; i < 300; i++) @(negedge clk);
    in_valid = 1'b0;
    for (int i = 0; i < 4; i++) @(negedge clk);
    checkOutput("sat_cnt", 32'(err_cnt), 32'd255);
    err_clr = 1'b1;
    @(negedge clk);
    err_clr = 1'b0;
    checkOutput("sat_clr_cnt", 32'(err_cnt), 32'd0);

    // Backpressure: third request waits while two are buffered.
    out_ready = 1'b0;
    driveFields(T_I, OPC_OP_IMM, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'd1);
    in_valid = 1'b1;
    @(negedge clk);
    driveFields(T_I, OPC_OP_IMM, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'd2);
    @(negedge clk);
    driveFields(T_I, OPC_OP_IMM, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'd3);
    checkOutput("bp_full_ready", 32'(in_ready), 32'd0);
    checkOutput("bp_head_inst", out_inst, 32'h00100093);
    @(negedge clk);
    checkOutput("bp_still_full", 32'(in_ready), 32'd0);
    checkOutput("bp_stable_inst", out_inst, 32'h00100093);
    checkOutput("bp_stable_valid", 32'(out_valid), 32'd1);
    out_ready = 1'b1;
    @(negedge clk);
    checkOutput("bp_second_inst", out_inst, 32'h00200093);
    checkOutput("bp_ready_again", 32'(in_ready), 32'd1);
    @(negedge clk);
    in_valid = 1'b0;
    checkOutput("bp_third_inst", out_inst, 32'h00300093);
    checkOutput("bp_third_valid", 32'(out_valid), 32'd1);
    @(negedge clk);
    checkOutput("bp_drained", 32'(out_valid), 32'd0);

    // Reset with two entries buffered: outputs drop without a clock edge.
    out_ready = 1'b0;
    in_valid  = 1'b1;
    @(negedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    checkOutput("pre_rst_valid", 32'(out_valid), 32'd1);
    #2 rst_n = 1'b0;
    #1;
    checkOutput("midrst_valid", 32'(out_valid), 32'd0);
    checkOutput("midrst_ready", 32'(in_ready), 32'd1);
    checkOutput("midrst_inst", out_inst, 32'h0);
    @(negedge clk);
    rst_n     = 1'b1;
    out_ready = 1'b1;
    @(negedge clk);
    @(negedge clk);
    checkOutput("post_rst_no_resp", 32'(out_valid), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/idu_inst_enc_ysyx_23060136.md
IDU_INST_ENC_YSYX_23060136 -- requirements
Module: idu_inst_enc_ysyx_23060136

Interface
REQ-001 SHALL have one clock and an asynchronous, active-low reset.
REQ-002 clk  input  1  rising-edge clock.
REQ-003 rst_n  input  1  asynchronous active-low reset.
REQ-004 in_valid/in_ready  input/output  1/1  request handshake; transfer when both high.
REQ-005 op_R_type, op_I_type, op_S_type, op_B_type, op_U_type, op_J_type  input  1 each  format select, one-hot.
REQ-006 in_opcode  input  7  opcode; in_rd, in_rs1, in_rs2  input  5 each  register fields.
REQ-007 in_funct3  input  3; in_funct7  input  7; in_imm  input  32  immediate value, two's complement.
REQ-008 out_valid/out_ready  output/input  1/1  response handshake; transfer when both high.
REQ-009 out_inst  output  32  encoded instruction; out_err  output  1  encoding error flag.
REQ-010 err_cnt  output  8  saturating count of erroneous responses; err_clr  input  1  synchronous clear.

Function
REQ-011 SHALL encode into a 32-bit RV32 word: [6:0]=opcode always; rd→[11:7] for R/I/U/J; funct3→[14:12], rs1→[19:15] for R/I/S/B; rs2→[24:20] for R/S/B; funct7→[31:25] for R only; all other bits zero.
REQ-012 I: [31:20]=imm[11:0].
REQ-013 S: [31:25]=imm[11:5], [11:7]=imm[4:0].
REQ-014 B: [31]=imm[12], [30:25]=imm[10:5], [11:8]=imm[4:1], [7]=imm[11].
REQ-015 U: [31:12]=imm[31:12].
REQ-016 J: [31]=imm[20], [30:21]=imm[10:1], [20]=imm[11], [19:12]=imm[19:12].
REQ-017 R: in_imm ignored.
REQ-018 Type not exactly one-hot (zero or ≥2 bits): out_inst=32'h0, out_err=1.
REQ-019 Encoding registered at acceptance; earliest out_valid is the cycle after the accepting edge (latency 1).
REQ-020 2-entry in-order buffer; in_ready = (occupancy < 2), registered state only, no combinational path from out_ready.
REQ-021 Push and pop in the same cycle: occupancy unchanged, order preserved.
REQ-022 out_valid = (occupancy > 0); out_inst/out_err stable while out_valid && !out_ready.
REQ-023 err_cnt increments by 1 on each pop with out_err=1; saturates at 255.
REQ-024 err_clr has priority over increment; err_cnt=0 next cycle.

Reset
REQ-025 On rst_n low: occupancy=0, out_valid=0, in_ready=1, out_inst=0, out_err=0, err_cnt=0, immediately, independent of clk.
REQ-026 Reset mid-operation discards buffered entries; no response is emitted for them.

Configuration
REQ-027 Macro IDU_INST_ENC_RANGE_CHECK_EN defined: out_err also set when imm is not representable — I/S outside -2048..2047; B outside -4096..4094 or imm[0]=1; J outside -1048576..1048574 or imm[0]=1; U with imm[11:0]≠0. out_inst still carries the truncated encoding.
REQ-028 Macro undefined: only the one-hot check of REQ-018 sets out_err; range logic absent.

Structure
REQ-029 Shared package SHALL hold format-type index constants, opcode constants, and immediate range bounds.
REQ-030 One sub-module: idu_enc_fifo_ysyx_23060136 (2-entry, 33-bit payload {err,inst}); encode logic stays in top.

Verification
REQ-031 I, opcode 0010011, rd=1, rs1=0, funct3=0, imm=5 → out_inst=32'h00500093, out_err=0, one cycle after accept.
REQ-032 B, opcode 1100011, rs1=rs2=0, funct3=0, imm=32'hFFFFFFFC → out_inst=32'hFE000EE3.
REQ-033 J, opcode 1101111, rd=1, imm=32'h800 → out_inst=32'h001000EF.
REQ-034 op_I_type and op_S_type both high → out_inst=0, out_err=1, err_cnt 0→1 on pop; err_clr → 0.
REQ-035 out_ready=0, three requests offered → two accepted, in_ready=0; release → responses in order, third accepted; rst_n low with two buffered → out_valid=0 immediately.
REQ-036 I, imm=2048: with macro out_err=1; without out_err=0; both out_inst[31:20]=12'h800.
